// File: rtl/adder_tree_accum.sv
// Frame accumulator behind the 2-level adder tree: sums frame_len beats and hands off total/count/overflow.
// Build option ADDER_ACCUM_SATURATE_EN clamps the accumulator to all-ones on carry-out instead of wrapping.
module adder_tree_accum #(
  parameter int ADDER_WIDTH = 21,
  parameter int ACC_WIDTH   = 32,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDER_WIDTH:0]   in_sum,
  input  logic [COUNT_WIDTH-1:0] frame_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_acc,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   overflow
);

  generate
    if (ACC_WIDTH < ADDER_WIDTH + 1) begin : g_bad_width
      $error("adder_tree_accum: ACC_WIDTH must be >= ADDER_WIDTH+1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [COUNT_WIDTH-1:0] r_len;
  logic                   r_overflow;

  logic                   w_accept;
  logic [ACC_WIDTH-1:0]   w_inExt;
  logic [ACC_WIDTH:0]     w_sum;
  logic [COUNT_WIDTH-1:0] w_cntInc;
  logic [COUNT_WIDTH-1:0] w_lenFirst;

  assign w_accept   = in_valid & in_ready;
  assign w_inExt    = ACC_WIDTH'(in_sum);
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_inExt};
  assign w_cntInc   = r_cnt + COUNT_WIDTH'(1);
  // A zero frame length would never terminate, so it is promoted to a single beat.
  assign w_lenFirst = (frame_len == '0) ? COUNT_WIDTH'(1) : frame_len;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~rst;
        if (w_accept) begin
          w_next = (w_lenFirst == COUNT_WIDTH'(1)) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = ~rst;
        if (w_accept && (w_cntInc == r_len)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && r_state == IDLE) begin
        r_acc      <= w_inExt;
        r_cnt      <= COUNT_WIDTH'(1);
        r_len      <= w_lenFirst;
        r_overflow <= 1'b0;
      end else if (w_accept && r_state == ACCUM) begin
        r_cnt      <= w_cntInc;
        r_overflow <= r_overflow | w_sum[ACC_WIDTH];
`ifdef ADDER_ACCUM_SATURATE_EN
        // Once the frame has overflowed the total is pinned at full scale.
        if (r_overflow | w_sum[ACC_WIDTH]) begin
          r_acc <= '1;
        end else begin
          r_acc <= w_sum[ACC_WIDTH-1:0];
        end
`else
        r_acc <= w_sum[ACC_WIDTH-1:0];
`endif
      end
    end
  end

  assign out_acc   = r_acc;
  assign out_count = r_cnt;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_adder_tree_accum.sv
// Self-checking bench for adder_tree_accum (ACC_WIDTH=23 so that carry-out is reachable with 22-bit sums).
// Honours ADDER_ACCUM_SATURATE_EN for the expected overflow total.
module tb_adder_tree_accum;

  localparam int AW = 21;
  localparam int CW = 23;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW:0]   in_sum;
  logic [NW-1:0] frame_len;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_acc;
  logic [NW-1:0] out_count;
  logic          overflow;

  int nChecks = 0;
  int nBad    = 0;

  typedef struct {
    logic [NW-1:0] len;
    int            n;
    logic [AW:0]   s [4];
    logic [CW-1:0] expAcc;
    logic [NW-1:0] expCnt;
    logic          expOvf;
  } vec_t;

  vec_t vecs[$];

  adder_tree_accum #(.ADDER_WIDTH(AW), .ACC_WIDTH(CW), .COUNT_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .frame_len(frame_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [NW-1:0] len, input int n,
                        input logic [AW:0] s0, input logic [AW:0] s1,
                        input logic [AW:0] s2, input logic [AW:0] s3,
                        input logic [CW-1:0] acc, input logic [NW-1:0] cnt, input logic ovf);
    vec_t v;
    v.len = len; v.n = n;
    v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
    v.expAcc = acc; v.expCnt = cnt; v.expOvf = ovf;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [AW:0] sum);
    in_valid = 1'b1;
    in_sum   = sum;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [CW-1:0] wrapExp;
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; frame_len = '0; out_ready = 1'b1;
`ifdef ADDER_ACCUM_SATURATE_EN
    wrapExp = 23'h7FFFFF;
`else
    wrapExp = 23'h3FFFFD;
`endif
    addVec(8'd4, 4, 22'd10, 22'd20, 22'd30, 22'd40, 23'd100, 8'd4, 1'b0);
    addVec(8'd3, 3, 22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF, 22'd0, wrapExp, 8'd3, 1'b1);
    addVec(8'd1, 1, 22'd5, 22'd0, 22'd0, 22'd0, 23'd5, 8'd1, 1'b0);
    addVec(8'd0, 1, 22'h3FFFFF, 22'd0, 22'd0, 22'd0, 23'h3FFFFF, 8'd1, 1'b0);
    addVec(8'd2, 2, 22'h3FFFFF, 22'd1, 22'd0, 22'd0, 23'h400000, 8'd2, 1'b0);

    tick(); tick();
    checkOutput("reset_in_ready_low", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_acc", {9'd0, out_acc}, 32'd0);

    // Table-driven back-to-back frames with out_ready held high.
    foreach (vecs[k]) begin
      frame_len = vecs[k].len;
      for (int i = 0; i < vecs[k].n; i++) begin
        checkOutput($sformatf("v%0d_ready_b%0d", k, i), {31'd0, in_ready}, 32'd1);
        checkOutput($sformatf("v%0d_early_b%0d", k, i), {31'd0, out_valid}, 32'd0);
        applyStimulus(vecs[k].s[i]);
      end
      checkOutput($sformatf("v%0d_valid", k), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("v%0d_acc", k), {9'd0, out_acc}, {9'd0, vecs[k].expAcc});
      checkOutput($sformatf("v%0d_count", k), {24'd0, out_count}, {24'd0, vecs[k].expCnt});
      checkOutput($sformatf("v%0d_ovf", k), {31'd0, overflow}, {31'd0, vecs[k].expOvf});
      tick();
      checkOutput($sformatf("v%0d_idle", k), {31'd0, out_valid}, 32'd0);
    end

    // Gapped input, then stalled output with in_valid asserted during DONE.
    frame_len = 8'd2;
    applyStimulus(22'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("gap_no_valid", {31'd0, out_valid}, 32'd0);
    end
    out_ready = 1'b0;
    applyStimulus(22'd8);
    in_valid = 1'b1; in_sum = 22'd100;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_acc", {9'd0, out_acc}, 32'd15);
      checkOutput("stall_count", {24'd0, out_count}, 32'd2);
      checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("stall_release", {31'd0, out_valid}, 32'd0);
    frame_len = 8'd1;
    applyStimulus(22'd3);
    checkOutput("not_consumed_acc", {9'd0, out_acc}, 32'd3);
    tick();

    // Reset partway through a 5-beat frame.
    frame_len = 8'd5;
    applyStimulus(22'd1);
    applyStimulus(22'd2);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mid_in_ready_after", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_mid_acc", {9'd0, out_acc}, 32'd0);
    frame_len = 8'd2;
    applyStimulus(22'd5);
    applyStimulus(22'd6);
    checkOutput("post_rst_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("post_rst_acc", {9'd0, out_acc}, 32'd11);
    tick();

    // frame_len changes after the first beat must not shorten the frame.
    frame_len = 8'd4;
    applyStimulus(22'd1);
    frame_len = 8'd2;
    applyStimulus(22'd2);
    checkOutput("len_change_b2", {31'd0, out_valid}, 32'd0);
    applyStimulus(22'd3);
    checkOutput("len_change_b3", {31'd0, out_valid}, 32'd0);
    applyStimulus(22'd4);
    checkOutput("len_change_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("len_change_acc", {9'd0, out_acc}, 32'd10);
    checkOutput("len_change_count", {24'd0, out_count}, 32'd4);
    tick();

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
